// File: rtl/pipe_id_hazard_pkg.sv
// rtl/pipe_id_hazard_pkg.sv - shared constants for the ID-stage hazard unit
package pipe_id_hazard_pkg;

    // Operand source selects
    localparam logic [1:0] FWD_RF   = 2'd0;  // register file
    localparam logic [1:0] FWD_EALU = 2'd1;  // E-stage ALU result
    localparam logic [1:0] FWD_MALU = 2'd2;  // M-stage ALU result
    localparam logic [1:0] FWD_MMEM = 2'd3;  // M-stage memory data

    localparam logic [31:0] NOP = 32'h0;

    // Register field positions inside an instruction word
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // True when a producer writes a real (non-zero) register matching rn
    function automatic logic hits(input logic wr, input logic [4:0] dst, input logic [4:0] rn);
        return wr && (dst != 5'd0) && (dst == rn);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// rtl/pipe_fwd_sel.sv - forwarding select for one source operand
//
// Ports: rn (operand register number), ewreg/em2reg/ern0 (E-stage producer),
//        mwreg/mm2reg/mrn (M-stage producer), sel (2-bit operand source).
module pipe_fwd_sel
    import pipe_id_hazard_pkg::*;
(
    input  logic [4:0] rn,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern0,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic [4:0] mrn,
    output logic [1:0] sel
);

    // E is checked first: the younger producer holds the newest value.
    // An E-stage load is not forwardable; the load-use stall covers it.
    always_comb begin
        sel = FWD_RF;
        if (hits(ewreg, ern0, rn) && !em2reg) begin
            sel = FWD_EALU;
        end else if (hits(mwreg, mrn, rn) && !mm2reg) begin
            sel = FWD_MALU;
        end else if (hits(mwreg, mrn, rn) && mm2reg) begin
            sel = FWD_MMEM;
        end
    end

endmodule

// File: rtl/pipe_id_hazard.sv
// rtl/pipe_id_hazard.sv - IF/ID register, load-use stall, forwarding and debug counters
//
// Ports: clk/resetn (async active-low), pc4/ins (IF stage), usea/useb (operand use),
//        dflush (squash next fetch), E/M producer signals, dpc4/inst (IF/ID register),
//        wpcir (PC/IF-ID enable), dbubble (zero ID/EXE control), fwda/fwdb (operand
//        selects), stall_cnt/flush_cnt (saturating statistics).
module pipe_id_hazard
    import pipe_id_hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      pc4,
    input  logic [31:0]      ins,
    input  logic             usea,
    input  logic             useb,
    input  logic             dflush,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern0,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    output logic [31:0]      dpc4,
    output logic [31:0]      inst,
    output logic             wpcir,
    output logic             dbubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [4:0] rs;
    logic [4:0] rt;
    logic       stall;

    assign rs = inst[RS_MSB:RS_LSB];
    assign rt = inst[RT_MSB:RT_LSB];

    // A load in E cannot supply its data until M, so a dependent instruction
    // in ID waits one cycle while a bubble is pushed into E.
    assign stall = ewreg && em2reg && (ern0 != 5'd0) &&
                   ((usea && (ern0 == rs)) || (useb && (ern0 == rt)));

    assign wpcir   = ~stall;
    assign dbubble = stall;

    pipe_fwd_sel u_fwd_a (
        .rn     (rs),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .ern0   (ern0),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .mrn    (mrn),
        .sel    (fwda)
    );

    pipe_fwd_sel u_fwd_b (
        .rn     (rt),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .ern0   (ern0),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .mrn    (mrn),
        .sel    (fwdb)
    );

    // Stall wins over flush: a branch still waiting on its operands has not resolved.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dpc4 <= 32'h0;
            inst <= NOP;
        end else if (!stall) begin
            dpc4 <= pc4;
            inst <= dflush ? NOP : ins;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!stall && dflush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipe_id_hazard.md
Name: pipe_id_hazard

Overview:
- ID-stage front end. Holds the IF/ID pipeline register (pc4, instruction).
- Observes the E-stage and M-stage destination and control signals (ewreg, em2reg, ern0; mwreg, mm2reg, mrn). From these it produces the forwarding selects, the load-use stall, and the bubble request that control decode uses to zero the ID/EXE inputs.
- Keeps saturating stall and flush counters for debug readout.

Parameters:
- CNT_W, 32, width of the stall and flush statistics counters.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- pc4  input  32  IF-stage PC+4
- ins  input  32  IF-stage fetched instruction
- usea  input  1  current ID instruction reads rs
- useb  input  1  current ID instruction reads rt
- dflush  input  1  taken branch/jump resolved in ID; squash next fetched instruction
- ewreg  input  1  E-stage writes register file
- em2reg  input  1  E-stage is a load
- ern0  input  5  E-stage destination register
- mwreg  input  1  M-stage writes register file
- mm2reg  input  1  M-stage is a load
- mrn  input  5  M-stage destination register
- dpc4  output  32  registered PC+4 for ID
- inst  output  32  registered instruction for ID
- wpcir  output  1  PC and IF/ID write enable; 0 = stall
- dbubble  output  1  1 = decode must drive zero control (dwreg, dm2reg, dwmem, djal) into the ID/EXE register
- fwda  output  2  rs operand select
- fwdb  output  2  rt operand select
- stall_cnt  output  CNT_W  cycles stalled
- flush_cnt  output  CNT_W  instructions squashed

Behaviour:
- Reset (resetn=0, asynchronous):
  - dpc4=0, inst=0 (NOP), stall_cnt=0, flush_cnt=0.
  - Combinational outputs still follow their equations with the reset register values.
- Register field decode: rs=inst[25:21], rt=inst[20:16].
- Load-use stall, combinational:
  - stall = ewreg & em2reg & (ern0!=0) & ((usea & ern0==rs) | (useb & ern0==rt)).
  - wpcir = ~stall; dbubble = stall.
- Forwarding, combinational, evaluated per operand X in {rs,rt}. Encoding: 0 register file, 1 E-stage ALU result, 2 M-stage ALU result, 3 M-stage memory data.
  - if ewreg & ~em2reg & ern0!=0 & ern0==X -> 1
  - else if mwreg & ~mm2reg & mrn!=0 & mrn==X -> 2
  - else if mwreg & mm2reg & mrn!=0 & mrn==X -> 3
  - else -> 0
- Priority: E over M (younger producer wins). Register 0 is never forwarded.
- Forward selects are computed regardless of usea/useb. They are still valid when stall=1, but decode discards them because the ID/EXE input is bubbled.
- IF/ID register update on rising clk, priority order:
  - stall=1: hold dpc4 and inst. The flush is ignored, because a branch in ID cannot resolve while its operands are stalled.
  - else dflush=1: dpc4<=pc4, inst<=0 (NOP); flush_cnt increments.
  - else: dpc4<=pc4, inst<=ins.
- Counters:
  - stall_cnt increments every cycle stall=1.
  - Both counters saturate at all-ones and never wrap.
- Latency: IF/ID is 1 cycle. Hazard and forward outputs are 0-cycle (combinational from current inst and E/M inputs).
- Stall duration: a load-use stall lasts exactly 1 cycle in normal flow, because the bubble clears em2reg in E on the next edge.
- Reset asserted mid-stall: registers clear immediately. After release, inst=0, so there is no stall and fwda=fwdb=0 while ern0=mrn=0.

Decomposition:
- Shared package:
  - FWD_RF=2'd0, FWD_EALU=2'd1, FWD_MALU=2'd2, FWD_MMEM=2'd3
  - NOP=32'h0, RS_MSB/LSB, RT_MSB/LSB field positions
- One natural sub-module: pipe_fwd_sel. It is purely combinational, instantiated twice (rs, rt), and takes one operand register number plus the E/M signals to produce the 2-bit select.

Test Plan:
1. Reset: resetn=0 mid-run with stall active -> dpc4=0, inst=0, counters=0 immediately without a clock edge. After release, wpcir=1, fwda=fwdb=0.
2. E forward: inst=ADD $3,$1,$2, usea=useb=1, ewreg=1, em2reg=0, ern0=1; mwreg=1, mm2reg=0, mrn=1 -> fwda=1 (E beats M), fwdb=0, wpcir=1.
3. M load forward: rt=$5, mwreg=1, mm2reg=1, mrn=5, ewreg=0 -> fwdb=3.
   - With ern0=0 and ewreg=1 targeting rs=$0 -> fwda=0 (r0 never forwarded).
4. Load-use: ewreg=1, em2reg=1, ern0=4, inst rs=4, usea=1 -> wpcir=0, dbubble=1; on next edge inst and dpc4 are unchanged and stall_cnt=1.
   - Repeat with usea=0 -> no stall.
5. Flush: dflush=1, ins=32'h8C220004, pc4=32'h104 -> next edge inst=0, dpc4=32'h104, flush_cnt=1.
   - With stall=1 and dflush=1 together -> hold, flush_cnt unchanged.
6. Saturation: CNT_W=4, hold load-use stall for 20 cycles -> stall_cnt stops at 15.
